register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_pkg.sv | 14 +
 rtl/register_file_mp_if.sv | 32 +++
 rtl/register_file_scoreboard.sv | 58 +++++
 rtl/register_file_mp.sv | 85 ++++++++
 tb/tb_register_file_mp.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared defaults and helpers for the multi-port register file with
// result-pending scoreboard.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_READ   = 2;

  // Low bit of read port 'port' inside the packed read_address bus.
  function automatic int addr_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bundle of write, reserve and read-port signals between the register file
// and whatever drives it (pipeline issue logic or a testbench).
interface register_file_mp_if
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
);

  logic                           write;
  logic [ADDR_WIDTH-1:0]          write_address;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           reserve;
  logic [ADDR_WIDTH-1:0]          reserve_address;
  logic [NUM_READ*ADDR_WIDTH-1:0] read_address;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ-1:0]            read_ready;
  logic                           reserve_error;
  logic [ADDR_WIDTH:0]            pending_count;

  modport master (
    output write, write_address, write_data, reserve, reserve_address, read_address,
    input  read_data, read_ready, reserve_error, pending_count
  );

  modport slave (
    input  write, write_address, write_data, reserve, reserve_address, read_address,
    output read_data, read_ready, reserve_error, pending_count
  );

endinterface

// File: rtl/register_file_scoreboard.sv
// Tracks which registers have a result outstanding, counts them, and flags
// a reserve of a register that is already pending.
module register_file_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic                    reserve,
  input  logic [ADDR_WIDTH-1:0]   reserve_address,
  output logic [2**ADDR_WIDTH-1:0] pending_next,
  output logic                    reserve_error,
  output logic [ADDR_WIDTH:0]     pending_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] pending;
  logic             write_ok;
  logic             reserve_ok;
  logic             same_address;
  logic             count_inc;
  logic             count_dec;
  logic             error_next;

  assign write_ok     = write && !((ZERO_REG != 0) && (write_address == '0));
  assign reserve_ok   = reserve && !((ZERO_REG != 0) && (reserve_address == '0));
  assign same_address = (write_address == reserve_address);

  // A reserve is applied after the write clear so a same-cycle pair leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (write_ok) pending_next[write_address] = 1'b0;
    if (reserve_ok) pending_next[reserve_address] = 1'b1;
  end

  assign count_inc  = reserve_ok && !pending[reserve_address];
  assign count_dec  = write_ok && pending[write_address] && !(reserve_ok && same_address);
  assign error_next = reserve_ok && pending[reserve_address] && !(write_ok && same_address);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      reserve_error <= 1'b0;
      pending_count <= '0;
    end else begin
      pending       <= pending_next;
      reserve_error <= error_next;
      if (count_inc && !count_dec)
        pending_count <= pending_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
      else if (count_dec && !count_inc)
        pending_count <= pending_count - {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with write-to-read bypass and a pending
// scoreboard that drives per-port read_ready.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ,
  parameter int ZERO_REG   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  register_file_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs       [DEPTH];
  logic [DEPTH-1:0]      pending_next;
  logic                  write_ok;
  logic [ADDR_WIDTH-1:0] rd_addr    [NUM_READ];
  logic [DATA_WIDTH-1:0] rd_data_d  [NUM_READ];
  logic [DATA_WIDTH-1:0] rd_data_q  [NUM_READ];
  logic [NUM_READ-1:0]   rd_ready_d;
  logic [NUM_READ-1:0]   rd_ready_q;

  assign write_ok = bus.write && !((ZERO_REG != 0) && (bus.write_address == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[bus.write_address] <= bus.write_data;
    end
  end

  register_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk             (clk),
    .rst_n           (rst_n),
    .write           (bus.write),
    .write_address   (bus.write_address),
    .reserve         (bus.reserve),
    .reserve_address (bus.reserve_address),
    .pending_next    (pending_next),
    .reserve_error   (bus.reserve_error),
    .pending_count   (bus.pending_count)
  );

  // Ready is judged against the pending state after this edge's write/reserve.
  always_comb begin
    rd_ready_d = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_addr[k] = bus.read_address[addr_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
      if ((ZERO_REG != 0) && (rd_addr[k] == '0))
        rd_data_d[k] = '0;
      else if (write_ok && (bus.write_address == rd_addr[k]))
        rd_data_d[k] = bus.write_data;
      else
        rd_data_d[k] = regs[rd_addr[k]];
      rd_ready_d[k] = !pending_next[rd_addr[k]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_READ; k++) rd_data_q[k] <= '0;
      rd_ready_q <= '0;
    end else begin
      for (int k = 0; k < NUM_READ; k++) rd_data_q[k] <= rd_data_d[k];
      rd_ready_q <= rd_ready_d;
    end
  end

  always_comb begin
    bus.read_data = '0;
    for (int k = 0; k < NUM_READ; k++)
      bus.read_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[k];
  end

  assign bus.read_ready = rd_ready_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vector table, a reset
// corner sequence and randomized traffic against an array-based model.
module tb_register_file_mp;
  import register_file_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  register_file_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR),
    .ZERO_REG   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: register contents and pending set; register 0 is never written or reserved.
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  logic [DW-1:0]    e_data [NR];
  logic             e_ready [NR];
  logic             e_err;
  int               e_cnt;

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rs;
    logic [AW-1:0] ra;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          y0;
    logic          y1;
    logic          err;
    int            cnt;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic wr, input int wa, input logic [DW-1:0] wd,
                              input logic rs, input int ra, input int r0, input int r1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic y0, input logic y1, input logic err, input int cnt);
    vec_t v;
    v.wr = wr; v.wa = AW'(wa); v.wd = wd; v.rs = rs; v.ra = AW'(ra);
    v.r0 = AW'(r0); v.r1 = AW'(r1); v.d0 = d0; v.d1 = d1;
    v.y0 = y0; v.y1 = y1; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveBus(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic rs, input logic [AW-1:0] ra,
                          input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    bus.write           = wr;
    bus.write_address   = wa;
    bus.write_data      = wd;
    bus.reserve         = rs;
    bus.reserve_address = ra;
    bus.read_address    = {r1, r0};
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pend = '0;
  endtask

  // Reads observe the register contents after this cycle's write and reserve.
  task automatic modelStep(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input logic rs, input logic [AW-1:0] ra,
                           input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    logic [AW-1:0] addrs [NR];
    e_err = rs && (ra != 0) && m_pend[ra] && !(wr && wa == ra);
    if (wr && wa != 0) begin
      m_mem[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (rs && ra != 0) m_pend[ra] = 1'b1;
    addrs[0] = r0;
    addrs[1] = r1;
    for (int k = 0; k < NR; k++) begin
      e_data[k]  = m_mem[addrs[k]];
      e_ready[k] = !m_pend[addrs[k]];
    end
    e_cnt = $countones(m_pend);
  endtask

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rs, input logic [AW-1:0] ra,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    driveBus(wr, wa, wd, rs, ra, r0, r1);
    modelStep(wr, wa, wd, rs, ra, r0, r1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " read_data"}, 64'(bus.read_data), 64'd0);
    checkOutput({tag, " read_ready"}, 64'(bus.read_ready), 64'd0);
    checkOutput({tag, " reserve_error"}, 64'(bus.reserve_error), 64'd0);
    checkOutput({tag, " pending_count"}, 64'(bus.pending_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 0, 0,            0, 0, 3, 0, 0,            0,            1, 1, 0, 0);
    vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0,            1, 7, 7, 5, 0,            32'hDEADBEEF, 0, 1, 0, 1);
    vecs[3]  = mk(1, 7, 32'h12,       0, 0, 7, 7, 32'h12,       32'h12,       1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0,            0, 0, 7, 0, 32'h12,       0,            1, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0,            1, 9, 9, 7, 0,            32'h12,       0, 1, 0, 1);
    vecs[6]  = mk(0, 0, 0,            1, 9, 9, 9, 0,            0,            0, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0,            0, 0, 9, 4, 0,            0,            0, 1, 0, 1);
    vecs[8]  = mk(1, 4, 32'h55,       1, 4, 4, 9, 32'h55,       0,            0, 0, 0, 2);
    vecs[9]  = mk(1, 0, 32'hFF,       0, 0, 0, 4, 0,            32'h55,       1, 0, 0, 2);
    vecs[10] = mk(0, 0, 0,            1, 0, 0, 0, 0,            0,            1, 1, 0, 2);
    vecs[11] = mk(1, 9, 32'hA5,       1, 3, 9, 3, 32'hA5,       0,            1, 0, 0, 2);
    vecs[12] = mk(1, 4, 32'h66,       0, 0, 4, 3, 32'h66,       0,            1, 0, 0, 1);

    rst_n = 1'b0;
    driveBus(0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #12;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rs, vecs[i].ra, vecs[i].r0, vecs[i].r1);
      checkOutput($sformatf("vec%0d read_data0", i), 64'(bus.read_data[0 +: DW]), 64'(vecs[i].d0));
      checkOutput($sformatf("vec%0d read_data1", i), 64'(bus.read_data[DW +: DW]), 64'(vecs[i].d1));
      checkOutput($sformatf("vec%0d read_ready0", i), 64'(bus.read_ready[0]), 64'(vecs[i].y0));
      checkOutput($sformatf("vec%0d read_ready1", i), 64'(bus.read_ready[1]), 64'(vecs[i].y1));
      checkOutput($sformatf("vec%0d reserve_error", i), 64'(bus.reserve_error), 64'(vecs[i].err));
      checkOutput($sformatf("vec%0d pending_count", i), 64'(bus.pending_count), 64'(vecs[i].cnt));
    end

    // Reserve r2 and r3, then pull reset in the middle of a write to r2.
    applyStimulus(0, 0, 0, 1, 2, 2, 0);
    applyStimulus(0, 0, 0, 1, 3, 2, 0);
    checkOutput("pre-reset pending_count", 64'(bus.pending_count), 64'(e_cnt));
    checkOutput("pre-reset read_ready1", 64'(bus.read_ready[1]), 64'd1);
    driveBus(1, 2, 32'h77, 0, 0, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("mid-reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    modelReset();
    driveBus(0, 0, 0, 0, 0, 2, 3);
    modelStep(0, 0, 0, 0, 0, 2, 3);
    @(posedge clk);
    #1;
    checkOutput("post-reset r2 data", 64'(bus.read_data[0 +: DW]), 64'd0);
    checkOutput("post-reset r2 ready", 64'(bus.read_ready[0]), 64'd1);
    checkOutput("post-reset r3 ready", 64'(bus.read_ready[1]), 64'd1);
    checkOutput("post-reset pending_count", 64'(bus.pending_count), 64'd0);

    for (int n = 0; n < 400; n++) begin
      logic          wr, rs;
      logic [AW-1:0] wa, ra, r0, r1;
      logic [DW-1:0] wd;
      wr = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 2) == 0);
      wa = AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      r0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 15));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : AW'($urandom_range(0, 15));
      wd = $urandom;
      applyStimulus(wr, wa, wd, rs, ra, r0, r1);
      checkOutput($sformatf("rand%0d read_data0", n), 64'(bus.read_data[0 +: DW]), 64'(e_data[0]));
      checkOutput($sformatf("rand%0d read_data1", n), 64'(bus.read_data[DW +: DW]), 64'(e_data[1]));
      checkOutput($sformatf("rand%0d read_ready0", n), 64'(bus.read_ready[0]), 64'(e_ready[0]));
      checkOutput($sformatf("rand%0d read_ready1", n), 64'(bus.read_ready[1]), 64'(e_ready[1]));
      checkOutput($sformatf("rand%0d reserve_error", n), 64'(bus.reserve_error), 64'(e_err));
      checkOutput($sformatf("rand%0d pending_count", n), 64'(bus.pending_count), 64'(e_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
